ghash_digit_mul: RTL and testbench
==================================

Name: ghash_digit_mul

Overview:
- Multi-cycle, digit-serial GF(2^128) multiplier for the GCM/GHASH datapath.
- Successor to the single-cycle fully unrolled multiplier.
- Processes DIGIT bits of the data operand per clock, which trades latency for area/timing.
- Adds valid/ready handshakes on both sides and an internal GHASH accumulator: Y <= (Y ^ X)·H.
- Sits between the AES-CTR ciphertext stream and the tag-generation logic.

Parameters:
- DIGIT, 8, bits of the data operand consumed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64, 128; any other value is an elaboration error.
- STEPS, 128/DIGIT, derived localparam (not overridable): cycles per multiply.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- iValid  in  1  input operand valid.
- oReady  out  1  block can accept an operand (high only in IDLE).
- iData  in  [0:127]  data block X; bit 0 = coefficient of x^0 (GCM bit order).
- iHashkey  in  [0:127]  hash key H, sampled on input handshake.
- iMode  in  1  0 = plain multiply (X·H); 1 = accumulate ((Y^X)·H).
- iClear  in  1  zero the accumulator Y.
- oValid  out  1  result valid.
- iReady  in  1  downstream accepts result.
- oResult  out  [0:127]  product.
- oAcc  out  [0:127]  current accumulator Y (GHASH running value).

Behaviour:
- Reset (rst=1 at a clock edge) forces: state IDLE, oReady=1, oValid=0, oResult=0, oAcc=0, step counter=0. This holds from any state and aborts any multiply in progress; no result is produced for an aborted operand.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY on iValid && oReady.
  - Latch A = iData ^ (iMode ? Y' : 0), where Y' = 0 if iClear is high that same cycle, else Y.
  - Latch V = iHashkey, Z = 0, mode bit, counter = 0.
- BUSY, each cycle:
  - For k = 0..DIGIT-1, in sequence, with bit index b = counter*DIGIT + k:
    - Z ^= V when A[b] = 1.
    - V = (V >> 1 in [0:127] order, i.e. {0, V[0:126]}) ^ (V[127] ? R : 0).
    - R = 0xE1 followed by 120 zero bits.
  - counter increments each cycle. After the STEPS-th cycle, go to DONE.
  - Latency: accept edge to oValid high = STEPS cycles (DIGIT=128 gives 1 cycle; DIGIT=8 gives 16 cycles).
- Entry to DONE:
  - oResult <= Z and oValid <= 1.
  - If the latched mode = 1, Y <= Z on the same edge.
- DONE:
  - oValid and oResult hold stable until iReady.
  - DONE -> IDLE on iReady; oValid drops the next cycle.
  - oResult keeps its last value after the transfer.
  - oReady is 0 in BUSY and DONE, so there is no overlap of operands (non-pipelined).
- iClear:
  - In IDLE with no handshake: Y <= 0 next edge.
  - In BUSY: ignored.
  - In DONE: Y <= 0, overriding the mode-1 update only if DONE is entered on that same edge. Clear has priority.
  - iMode, iData, iHashkey are don't-care outside the input handshake cycle.
- iMode = 0 never modifies Y.
- Y persists across plain multiplies.

Decomposition:
- Package ghash_pkg:
  - GF_W = 128.
  - GF_R constant (0xE1 << 120).
  - Legal-DIGIT check function.
  - FSM state enum (IDLE/BUSY/DONE).
- Sub-module gf128_digit_step (combinational):
  - Inputs: Z, V, DIGIT data bits.
  - Outputs: next Z, next V.
  - Holds the DIGIT-deep unrolled shift/xor chain.
  - Reusable by the future unrolled/pipelined variants.
- Top level: FSM, counter, operand registers, accumulator, handshakes.

Test Plan:
- Identity: H=80000000000000000000000000000000, X=0388dace60b6a392f328c2b971b2fe78, iMode=0 -> oResult=0388dace60b6a392f328c2b971b2fe78 after exactly STEPS cycles; oAcc stays 0.
- GCM vector: H=66e94bd4ef8a2c3b884cfa59ca342b2e, iClear=1 with first accept.
  - X=0388dace60b6a392f328c2b971b2fe78, iMode=1 -> oResult=oAcc=5e2ec746917062882c85b0685353deb7.
  - Then X=00000000000000000000000000000080, iMode=1 -> oResult=oAcc=f38cbb1ad69223dcc3457ae5b6b0f885.
- Latency sweep: repeat the GCM vector for DIGIT=1, 8, 32, 128 -> identical results; oValid at 128, 16, 4, 1 cycles after accept; oReady=0 throughout BUSY/DONE.
- Back-pressure: iReady=0 for 10 cycles after oValid -> oValid/oResult stable; iValid held high is not accepted until the cycle after the iReady transfer.
- Reset mid-operation: rst=1 at BUSY step STEPS/2 -> next cycle oValid=0, oResult=0, oAcc=0, oReady=1; a following X·H with zero H yields 0.
- Clear priority: iClear=1 in the same cycle DONE is entered in mode 1 -> oAcc=0, oResult=Z unchanged.

Source files
------------

// File: rtl/ghash_pkg.sv
// Shared GF(2^128) constants, FSM states and the DIGIT legality check
// for the GHASH multiplier family.
package ghash_pkg;

    localparam int GF_W = 128;

    // GCM bit order: index 0 is the coefficient of x^0
    typedef logic [0:GF_W-1] gf_t;

    localparam gf_t GF_R = {8'hE1, 120'b0};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic bit digitLegal(input int d);
        case (d)
            1, 2, 4, 8, 16, 32, 64, 128: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gf128_digit_step.sv
// One clock's worth of the GCM right-shift multiply: DIGIT data bits are
// folded into Z while V is shifted and reduced DIGIT times.
module gf128_digit_step
    import ghash_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  gf_t              z,
    input  gf_t              v,
    input  logic [0:DIGIT-1] d,
    output gf_t              zNext,
    output gf_t              vNext
);

    gf_t zAcc;
    gf_t vAcc;

    // Bit d[0] is consumed first; each iteration mirrors one serial step
    always_comb begin
        zAcc = z;
        vAcc = v;
        for (int k = 0; k < DIGIT; k++) begin
            if (d[k]) begin
                zAcc = zAcc ^ vAcc;
            end
            vAcc = {1'b0, vAcc[0:GF_W-2]} ^ (vAcc[GF_W-1] ? GF_R : '0);
        end
        zNext = zAcc;
        vNext = vAcc;
    end

endmodule

// File: rtl/ghash_digit_mul.sv
// Digit-serial GF(2^128) multiplier with GHASH accumulator Y <= (Y ^ X)·H
// and valid/ready handshakes on both sides.
module ghash_digit_mul
    import ghash_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iValid,
    output logic        oReady,
    input  logic [0:127] iData,
    input  logic [0:127] iHashkey,
    input  logic        iMode,
    input  logic        iClear,
    output logic        oValid,
    input  logic        iReady,
    output logic [0:127] oResult,
    output logic [0:127] oAcc
);

    localparam int STEPS = GF_W / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (!digitLegal(DIGIT)) begin : gBadDigit
            $error("ghash_digit_mul: DIGIT must be a power of two from 1 to 128");
        end
    endgenerate

    state_t         state;
    state_t         stateNext;
    gf_t            aReg;
    gf_t            vReg;
    gf_t            zReg;
    gf_t            accReg;
    gf_t            resultReg;
    logic           modeReg;
    logic           validReg;
    logic [CW-1:0]  count;
    gf_t            zStep;
    gf_t            vStep;
    logic           lastStep;

    assign lastStep = (count == CW'(STEPS - 1));

    // A is shifted toward index 0, so the current digit is always its head
    gf128_digit_step #(
        .DIGIT (DIGIT)
    ) uStep (
        .z     (zReg),
        .v     (vReg),
        .d     (aReg[0:DIGIT-1]),
        .zNext (zStep),
        .vNext (vStep)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iValid)   stateNext = BUSY;
            BUSY:    if (lastStep) stateNext = DONE;
            DONE:    if (iReady)   stateNext = IDLE;
            default:               stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            aReg      <= '0;
            vReg      <= '0;
            zReg      <= '0;
            accReg    <= '0;
            resultReg <= '0;
            modeReg   <= 1'b0;
            validReg  <= 1'b0;
            count     <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (iValid) begin
                        aReg    <= iData ^ ((iMode && !iClear) ? accReg : '0);
                        vReg    <= iHashkey;
                        zReg    <= '0;
                        modeReg <= iMode;
                        count   <= '0;
                    end else if (iClear) begin
                        accReg <= '0;
                    end
                end
                BUSY: begin
                    zReg  <= zStep;
                    vReg  <= vStep;
                    aReg  <= aReg << DIGIT;
                    count <= count + CW'(1);
                    // A clear arriving on the DONE-entry edge beats the mode-1 update
                    if (lastStep) begin
                        resultReg <= zStep;
                        validReg  <= 1'b1;
                        if (iClear) begin
                            accReg <= '0;
                        end else if (modeReg) begin
                            accReg <= zStep;
                        end
                    end
                end
                DONE: begin
                    if (iClear) begin
                        accReg <= '0;
                    end
                    if (iReady) begin
                        validReg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oReady  = (state == IDLE);
    assign oValid  = validReg;
    assign oResult = resultReg;
    assign oAcc    = accReg;

endmodule

// File: tb/tb_ghash_digit_mul.sv
// Self-checking bench: fixed GCM vectors, handshake corner cases, random
// operations against a polynomial-arithmetic model, and a DIGIT latency sweep.
module tb_ghash_digit_mul;
    import ghash_pkg::*;

    localparam int MAIN_DIGIT = 8;
    localparam int STEPS      = 128 / MAIN_DIGIT;

    logic clk;
    logic rst;
    logic iValid, oReady, iMode, iClear, oValid, iReady;
    gf_t  iData, iHashkey, oResult, oAcc;

    logic sValid, sMode, sClear, sReady;
    gf_t  sData, sKey;
    logic swReady [4];
    logic swValid [4];
    gf_t  swResult [4];
    gf_t  swAcc [4];

    int applied;
    int miscompares;
    gf_t modelY;

    ghash_digit_mul #(
        .DIGIT (MAIN_DIGIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iValid   (iValid),
        .oReady   (oReady),
        .iData    (iData),
        .iHashkey (iHashkey),
        .iMode    (iMode),
        .iClear   (iClear),
        .oValid   (oValid),
        .iReady   (iReady),
        .oResult  (oResult),
        .oAcc     (oAcc)
    );

    // Four widths side by side, fed identical operands
    for (genvar g = 0; g < 4; g++) begin : gSweep
        localparam int D = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 32 : 128;
        ghash_digit_mul #(
            .DIGIT (D)
        ) uSweep (
            .clk      (clk),
            .rst      (rst),
            .iValid   (sValid),
            .oReady   (swReady[g]),
            .iData    (sData),
            .iHashkey (sKey),
            .iMode    (sMode),
            .iClear   (sClear),
            .oValid   (swValid[g]),
            .iReady   (sReady),
            .oResult  (swResult[g]),
            .oAcc     (swAcc[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        gf_t  x;
        gf_t  h;
        logic mode;
        logic clear;
        gf_t  expResult;
        gf_t  expAcc;
    } vec_t;

    vec_t table_v [4];

    // Product of two field elements via polynomial multiply then reduction
    // modulo x^128 + x^7 + x^2 + x + 1.
    function automatic gf_t gfMul(input gf_t a, input gf_t b);
        logic [254:0] p;
        gf_t r;
        p = '0;
        for (int i = 0; i < 128; i++) begin
            if (a[i]) begin
                for (int j = 0; j < 128; j++) begin
                    if (b[j]) p[i+j] = ~p[i+j];
                end
            end
        end
        for (int i = 254; i >= 128; i--) begin
            if (p[i]) begin
                p[i]     = 1'b0;
                p[i-121] = ~p[i-121];
                p[i-126] = ~p[i-126];
                p[i-127] = ~p[i-127];
                p[i-128] = ~p[i-128];
            end
        end
        for (int i = 0; i < 128; i++) r[i] = p[i];
        return r;
    endfunction

    function automatic gf_t randGf();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int sweepDigit(input int g);
        return (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 32 : 128;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Full transaction on the main DUT; caller guarantees IDLE on entry
    task automatic applyStimulus(input gf_t x, input gf_t h, input logic mode,
                                 input logic clear, input int readyDelay,
                                 output gf_t res, output int lat, output logic hsOk);
        iData = x; iHashkey = h; iMode = mode; iClear = clear; iValid = 1'b1;
        hsOk = oReady;
        @(posedge clk); #1;
        iValid = 1'b0; iClear = 1'b0; iData = randGf(); iMode = $urandom_range(0, 1);
        lat = 0;
        while (!oValid && lat < 300) begin
            if (oReady) hsOk = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = oResult;
        for (int i = 0; i < readyDelay; i++) begin
            if (!oValid || oResult !== res || oReady) hsOk = 1'b0;
            @(posedge clk); #1;
        end
        iReady = 1'b1;
        @(posedge clk); #1;
        iReady = 1'b0;
        if (oValid || !oReady || oResult !== res) hsOk = 1'b0;
    endtask

    task automatic runModelOp(input string name, input gf_t x, input gf_t h,
                              input logic mode, input logic clear, input int delay);
        gf_t a, expR, res;
        int lat;
        logic hsOk;
        a = mode ? (x ^ (clear ? gf_t'(0) : modelY)) : x;
        expR = gfMul(a, h);
        if (mode) modelY = expR;
        applyStimulus(x, h, mode, clear, delay, res, lat, hsOk);
        checkOutput({name, " result"}, res, expR);
        checkOutput({name, " latency"}, 128'(lat), 128'(STEPS));
        checkOutput({name, " acc"}, oAcc, modelY);
        checkOutput({name, " handshake"}, 128'(hsOk), 128'(1));
    endtask

    initial begin
        gf_t res, expR, x2, h2;
        int lat;
        logic hsOk, stable;
        int swLat [4];
        logic swDone [4];
        int nDone;

        applied = 0; miscompares = 0; modelY = '0;
        rst = 1'b1; iValid = 0; iMode = 0; iClear = 0; iReady = 0;
        iData = '0; iHashkey = '0;
        sValid = 0; sMode = 0; sClear = 0; sReady = 0; sData = '0; sKey = '0;

        table_v[0] = '{128'h0388dace60b6a392f328c2b971b2fe78, 128'h80000000000000000000000000000000,
                       1'b0, 1'b0, 128'h0388dace60b6a392f328c2b971b2fe78, 128'h0};
        table_v[1] = '{128'h0388dace60b6a392f328c2b971b2fe78, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                       1'b1, 1'b1, 128'h5e2ec746917062882c85b0685353deb7,
                       128'h5e2ec746917062882c85b0685353deb7};
        table_v[2] = '{128'h00000000000000000000000000000080, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                       1'b1, 1'b0, 128'hf38cbb1ad69223dcc3457ae5b6b0f885,
                       128'hf38cbb1ad69223dcc3457ae5b6b0f885};
        table_v[3] = '{128'hfeedfacedeadbeeffeedfacedeadbeef, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                       1'b0, 1'b0,
                       gfMul(128'hfeedfacedeadbeeffeedfacedeadbeef, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e),
                       128'hf38cbb1ad69223dcc3457ae5b6b0f885};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset oReady", 128'(oReady), 128'(1));
        checkOutput("reset oValid", 128'(oValid), 128'(0));
        checkOutput("reset oResult", oResult, 128'h0);
        checkOutput("reset oAcc", oAcc, 128'h0);

        $display("[TB] fixed vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(table_v[i].x, table_v[i].h, table_v[i].mode, table_v[i].clear,
                          i, res, lat, hsOk);
            checkOutput($sformatf("vec%0d result", i), res, table_v[i].expResult);
            checkOutput($sformatf("vec%0d acc", i), oAcc, table_v[i].expAcc);
            checkOutput($sformatf("vec%0d latency", i), 128'(lat), 128'(STEPS));
            checkOutput($sformatf("vec%0d handshake", i), 128'(hsOk), 128'(1));
        end
        modelY = table_v[3].expAcc;

        $display("[TB] back-pressure with iValid held");
        h2 = randGf(); x2 = randGf();
        expR = gfMul(table_v[3].x, h2);
        iData = table_v[3].x; iHashkey = h2; iMode = 1'b0; iValid = 1'b1;
        @(posedge clk); #1;
        iData = x2;
        lat = 0;
        while (!oValid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp latency", 128'(lat), 128'(STEPS));
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!oValid || oResult !== expR || oReady) stable = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("bp stable", 128'(stable), 128'(1));
        iReady = 1'b1;
        @(posedge clk); #1;
        iReady = 1'b0;
        checkOutput("bp oValid drop", 128'(oValid), 128'(0));
        checkOutput("bp oReady after transfer", 128'(oReady), 128'(1));
        checkOutput("bp result kept", oResult, expR);
        @(posedge clk); #1;
        iValid = 1'b0;
        checkOutput("bp second accepted", 128'(oReady), 128'(0));
        lat = 0;
        while (!oValid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp second latency", 128'(lat), 128'(STEPS));
        checkOutput("bp second result", oResult, gfMul(x2, h2));
        iReady = 1'b1;
        @(posedge clk); #1;
        iReady = 1'b0;

        $display("[TB] clear on DONE entry");
        h2 = randGf(); x2 = randGf();
        expR = gfMul(x2 ^ modelY, h2);
        iData = x2; iHashkey = h2; iMode = 1'b1; iValid = 1'b1;
        @(posedge clk); #1;
        iValid = 1'b0;
        repeat (STEPS - 1) @(posedge clk);
        #1 iClear = 1'b1;
        @(posedge clk); #1;
        checkOutput("clr oValid", 128'(oValid), 128'(1));
        @(posedge clk); #1;
        iClear = 1'b0;
        checkOutput("clr acc", oAcc, 128'h0);
        checkOutput("clr result", oResult, expR);
        modelY = '0;
        iReady = 1'b1;
        @(posedge clk); #1;
        iReady = 1'b0;

        $display("[TB] random operations");
        for (int n = 0; n < 30; n++) begin
            logic m, c;
            if ($urandom_range(0, 4) == 0) begin
                iClear = 1'b1;
                @(posedge clk); #1;
                iClear = 1'b0;
                modelY = '0;
                checkOutput($sformatf("rnd%0d idle clear", n), oAcc, 128'h0);
            end
            m = $urandom_range(0, 1);
            c = m && ($urandom_range(0, 3) == 0);
            runModelOp($sformatf("rnd%0d", n), randGf(), randGf(), m, c, $urandom_range(0, 3));
        end

        $display("[TB] reset mid-operation");
        iData = randGf(); iHashkey = randGf(); iMode = 1'b1; iValid = 1'b1;
        @(posedge clk); #1;
        iValid = 1'b0;
        repeat (STEPS / 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid-rst oValid", 128'(oValid), 128'(0));
        checkOutput("mid-rst oResult", oResult, 128'h0);
        checkOutput("mid-rst oAcc", oAcc, 128'h0);
        checkOutput("mid-rst oReady", 128'(oReady), 128'(1));
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (oValid || !oReady) stable = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("mid-rst no result", 128'(stable), 128'(1));
        modelY = '0;
        runModelOp("zero key", randGf(), '0, 1'b0, 1'b0, 0);
        checkOutput("zero key product", oResult, 128'h0);

        $display("[TB] latency sweep");
        for (int op = 0; op < 2; op++) begin
            sData  = (op == 0) ? 128'h0388dace60b6a392f328c2b971b2fe78
                               : 128'h00000000000000000000000000000080;
            expR   = (op == 0) ? 128'h5e2ec746917062882c85b0685353deb7
                               : 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
            sKey   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
            sMode  = 1'b1;
            sClear = (op == 0);
            sValid = 1'b1;
            @(posedge clk); #1;
            sValid = 1'b0; sClear = 1'b0;
            stable = 1'b1;
            nDone = 0;
            for (int g = 0; g < 4; g++) begin
                swDone[g] = 1'b0;
                swLat[g]  = 0;
            end
            for (int c = 1; c <= 200 && nDone < 4; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 4; g++) begin
                    if (swReady[g]) stable = 1'b0;
                    if (!swDone[g] && swValid[g]) begin
                        swDone[g] = 1'b1;
                        swLat[g]  = c;
                        nDone++;
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                checkOutput($sformatf("sweep%0d D%0d latency", op, sweepDigit(g)),
                            128'(swLat[g]), 128'(128 / sweepDigit(g)));
                checkOutput($sformatf("sweep%0d D%0d result", op, sweepDigit(g)),
                            swResult[g], expR);
                checkOutput($sformatf("sweep%0d D%0d acc", op, sweepDigit(g)),
                            swAcc[g], expR);
            end
            checkOutput($sformatf("sweep%0d oReady low", op), 128'(stable), 128'(1));
            sReady = 1'b1;
            @(posedge clk); #1;
            sReady = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
